inst_fetch_queue: RTL
=====================

# inst_fetch_queue

Parametrised instruction queue between the fetch stage (PC register + instruction RAM read) and the decode stage. It replaces the single-entry IF/ID register with a circular buffer. Each cycle the buffer accepts up to FETCH_WIDTH {pc, instruction} pairs and presents up to ISSUE_WIDTH oldest entries to decode in first-word fall-through order. A branch redirect flushes the whole buffer, and backpressure is signalled to fetch.

## Interface
Parameters:
- DEPTH, 8: number of entries; power of two, ≥ FETCH_WIDTH and ≥ ISSUE_WIDTH.
- FETCH_WIDTH, 2: instruction slots pushed per cycle.
- ISSUE_WIDTH, 2: instruction slots presented per cycle.
- ADDR_WIDTH, 32: PC width.
- INST_WIDTH, 32: instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- flush_i  in  1  branch redirect; discard all entries.
- push_valid_i  in  FETCH_WIDTH  per-slot valid; must be a prefix mask (slot 0 first).
- push_pc_i  in  FETCH_WIDTH*ADDR_WIDTH  slot k PC at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- push_inst_i  in  FETCH_WIDTH*INST_WIDTH  slot k instruction.
- push_ready_o  out  1  free entries ≥ FETCH_WIDTH.
- pop_ready_i  in  1  decode consumes every presented valid slot this cycle.
- pop_valid_o  out  ISSUE_WIDTH  per-slot valid, prefix mask.
- pop_pc_o  out  ISSUE_WIDTH*ADDR_WIDTH  oldest-first PCs.
- pop_inst_o  out  ISSUE_WIDTH*INST_WIDTH  oldest-first instructions.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: DEPTH entries of {pc, inst}, plus a read pointer rd_ptr, a write pointer wr_ptr (both $clog2(DEPTH) bits, wrapping mod DEPTH) and a registered count.
- Push fires when `|push_valid_i && push_ready_o && !flush_i`.
  - n_push = popcount(push_valid_i).
  - Slot k is written to entry (wr_ptr+k) mod DEPTH.
  - wr_ptr advances by n_push.
- A push offered while push_ready_o=0 is dropped. Fetch must hold the slot group and retry.
- Pop outputs:
  - n_avail = min(count, ISSUE_WIDTH).
  - Slot j shows entry (rd_ptr+j) mod DEPTH.
  - pop_valid_o[j] = (j < n_avail).
  - Invalid slots drive pc/inst = 0.
- Pop fires when `pop_ready_i && !flush_i`. It removes n_avail entries and rd_ptr advances by n_avail. With count=0 it has no effect.
- Count update: count_next = count + n_push − n_pop. It never exceeds DEPTH because push_ready_o is sized conservatively.
- Flush: at the edge, rd_ptr, wr_ptr and count all become 0. Flush wins over a same-cycle push and pop; neither takes effect.
- Non-prefix push_valid_i is illegal. The bench asserts against it; RTL behaviour is undefined.

## Timing
- Reset (rst=0 at an edge) state:
  - pointers=0, count=0.
  - pop_valid_o=0, pop_pc_o=0, pop_inst_o=0, count_o=0.
  - push_ready_o=1.
- Storage contents are not reset.
- Push-to-pop latency is 1 cycle: a pushed entry is visible on pop outputs the cycle after the push edge.
- pop_* and count_o come from registered state only. There is no combinational path from push_* or pop_ready_i to them.
- push_ready_o = (DEPTH − count ≥ FETCH_WIDTH), from registered count only.
  - A same-cycle pop does not free space for a same-cycle push.
  - There is no combinational pop→push path.
- Simultaneous push and pop: both apply. Example: count 3 → 3 + 2 − 2 = 3.
- Wrap-around: pointers roll from DEPTH−1 to 0 mid-group. Slot order is preserved.
- Full: count=DEPTH gives push_ready_o=0, and pop still works.
- Empty: count=0 gives pop_valid_o=0, and a push still works.
- Reset or flush asserted mid-stream discards in-flight entries with no partial pop.

## Structure
- Shared package (extend defines): FETCH_WIDTH, ISSUE_WIDTH and DEPTH defaults.
- Add an inst_entry_t packed struct {pc, inst} alongside the existing InstAddrBus/InstBus widths.
- Sub-module: popcount_prefix, a combinational count of a prefix mask. It is instantiated for push and is reusable by decode.
- The queue itself is a single module.

## Test plan
All scenarios use DEPTH=8, FW=2, IW=2.
- Reset check: hold rst=0 for 2 cycles, release → count_o=0, pop_valid_o=2'b00, push_ready_o=1.
- Single push and pop: push valid 2'b11 (PC 0x1c000000/0x1c000004), pop_ready=0 → next cycle pop_valid_o=2'b11 with PCs in order and count_o=2. Then pop_ready=1 → count_o=0.
- Fill to full: 4 pushes of 2'b11 with no pop → count_o=8, push_ready_o=0. A fifth push is dropped and count stays 8.
- Wrap-around: pointers at 6, push 4 entries with a concurrent pop of 2 → entries 6, 7, 0, 1 come out in PC order with no loss.
- Flush priority: count=5, then flush_i=1 together with push 2'b11 and pop_ready=1 → next cycle count_o=0, pop_valid_o=0, push_ready_o=1.
- Partial slots and conservative ready: push 2'b01 → count 1, pop_valid_o=2'b01. At count=7 with a pop, push_ready_o=0 and the push is not accepted that cycle.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch/decode definitions: bus widths, queue default geometry and the
// {pc, inst} entry type carried between fetch and decode.
package inst_fetch_queue_pkg;

  localparam int INST_ADDR_BUS       = 32;
  localparam int INST_BUS            = 32;
  localparam int DEPTH_DEFAULT       = 8;
  localparam int FETCH_WIDTH_DEFAULT = 2;
  localparam int ISSUE_WIDTH_DEFAULT = 2;

  typedef struct packed {
    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_BUS-1:0]      inst;
  } inst_entry_t;

endpackage

// File: rtl/inst_fetch_queue_popcount_prefix.sv
// Number of set slots in a slot-valid mask; shared by the fetch queue and decode.
module popcount_prefix
  import inst_fetch_queue_pkg::*;
#(
  parameter int W = FETCH_WIDTH_DEFAULT
) (
  input  logic [W-1:0]             mask,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int CW = $clog2(W + 1);

  // Sum of set bits in the mask
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(mask[i]);
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular instruction buffer between fetch and decode: multi-slot push,
// first-word fall-through multi-slot pop, whole-buffer flush on redirect.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEFAULT,
  parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH  = INST_ADDR_BUS,
  parameter int INST_WIDTH  = INST_BUS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_i,
  input  logic [FETCH_WIDTH-1:0]            push_valid_i,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] push_pc_i,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0] push_inst_i,
  output logic                              push_ready_o,
  input  logic                              pop_ready_i,
  output logic [ISSUE_WIDTH-1:0]            pop_valid_o,
  output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0] pop_pc_o,
  output logic [ISSUE_WIDTH*INST_WIDTH-1:0] pop_inst_o,
  output logic [$clog2(DEPTH+1)-1:0]        count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NP_W  = $clog2(FETCH_WIDTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FETCH_CNT = CNT_W'(FETCH_WIDTH);
  localparam logic [CNT_W-1:0] ISSUE_CNT = CNT_W'(ISSUE_WIDTH);

  logic [ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_r [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [NP_W-1:0]       n_valid_s;
  logic [NP_W-1:0]       n_push_s;
  logic [CNT_W-1:0]      n_avail_s;
  logic [CNT_W-1:0]      n_pop_s;
  logic                  push_fire_s;
  logic                  pop_fire_s;

  popcount_prefix #(.W(FETCH_WIDTH)) u_push_count (
    .mask  (push_valid_i),
    .count (n_valid_s)
  );

  // Ready depends on registered count only, so a same-cycle pop never frees room.
  assign push_ready_o = (DEPTH_CNT - count_r) >= FETCH_CNT;
  assign push_fire_s  = (|push_valid_i) && push_ready_o && !flush_i;
  assign pop_fire_s   = pop_ready_i && !flush_i;
  assign n_avail_s    = (count_r < ISSUE_CNT) ? count_r : ISSUE_CNT;
  assign n_push_s     = push_fire_s ? n_valid_s : '0;
  assign n_pop_s      = pop_fire_s ? n_avail_s : '0;
  assign count_o      = count_r;

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (push_fire_s && push_valid_i[k]) begin
        pc_mem_r[wr_ptr_r + PTR_W'(k)]   <= push_pc_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        inst_mem_r[wr_ptr_r + PTR_W'(k)] <= push_inst_i[k*INST_WIDTH +: INST_WIDTH];
      end
    end
  end

  // Pointer and occupancy bookkeeping; flush beats any same-cycle push or pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_r + PTR_W'(n_pop_s);
      wr_ptr_r <= wr_ptr_r + PTR_W'(n_push_s);
      count_r  <= count_r + CNT_W'(n_push_s) - n_pop_s;
    end
  end

  // Oldest-first presentation to decode; empty slots are zeroed
  always_comb begin
    pop_valid_o = '0;
    pop_pc_o    = '0;
    pop_inst_o  = '0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      if (CNT_W'(j) < n_avail_s) begin
        pop_valid_o[j]                        = 1'b1;
        pop_pc_o[j*ADDR_WIDTH +: ADDR_WIDTH]   = pc_mem_r[rd_ptr_r + PTR_W'(j)];
        pop_inst_o[j*INST_WIDTH +: INST_WIDTH] = inst_mem_r[rd_ptr_r + PTR_W'(j)];
      end else begin
        pop_valid_o[j] = 1'b0;
      end
    end
  end

endmodule
